control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Microcoded T-state sequencer for the ASAP-1 CPU. Steps each instruction through fetch and execute.
//  Drives every bus output-enable and register-load strobe, including the ALU oe/sub controls.
//  Holds the ZF/CF flags register. Evaluates conditional jumps. Implements HLT.
//  Sits between the IR opcode field and all datapath modules on the shared 8-bit bus.
// PARAMETERS
//  MAX_STEPS  5  T-states per instruction (T0..T4); t_state wraps at MAX_STEPS-1
//  OPCODE_W   4  opcode width (IR[7:4])
// PORTS
//  clk       in   1  system clock, all state updates on rising edge
//  rst_n     in   1  reset, synchronous, active-low
//  opcode    in   4  current IR[7:4], stable from T2 onward
//  zf        in   1  ALU zero flag (combinational from ALU)
//  cf        in   1  ALU carry flag (combinational from ALU)
//  t_state   out  3  current T-state, debug/LED
//  pc_oe pc_inc pc_ld mar_ld ram_oe ram_we ir_ld ir_oe  out 1 each  control strobes
//  a_ld a_oe b_ld alu_oe alu_sub out_ld flags_ld       out 1 each  control strobes
//  halt      out  1  sticky halted indication
// BEHAVIOUR
//  - State: t_state[2:0], halted, zf_q, cf_q; all cleared on the rising edge with rst_n=0.
//  - While rst_n=0, all strobes are forced 0 combinationally.
//  - Strobes are combinational from (t_state, opcode, zf_q, cf_q). Datapath samples them on the next edge.
//  - Opcode-independent steps:
//    - T0: pc_oe, mar_ld.
//    - T1: ram_oe, ir_ld, pc_inc.
//  - Execute steps T2/T3/T4 by opcode:
//    - NOP 0000: none.
//    - LDA 0001: ir_oe+mar_ld / ram_oe+a_ld / none.
//    - ADD 0010: ir_oe+mar_ld / ram_oe+b_ld / alu_oe+a_ld+flags_ld.
//    - SUB 0011: as ADD; alu_sub=1 in T3 and T4.
//    - STA 0100: ir_oe+mar_ld / a_oe+ram_we / none.
//    - LDI 0101: ir_oe+a_ld in T2.
//    - JMP 0110: ir_oe+pc_ld in T2.
//    - JC 0111: ir_oe+pc_ld in T2 only if cf_q=1.
//    - JZ 1000: ir_oe+pc_ld in T2 only if zf_q=1.
//    - OUT 1110: a_oe+out_ld in T2.
//    - HLT 1111: sets halted at the end of T2.
//    - 1001-1101: treated as NOP.
//  - Invariant: at most one *_oe asserted in any cycle (bus contention forbidden).
//  - Flags: zf_q<=zf, cf_q<=cf on the edge ending a flags_ld cycle; otherwise hold. JC/JZ use only the registered copies.
//  - Stepping: t_state increments each cycle and returns to 0 after T4 (MAX_STEPS-1).
//  - Halted: t_state frozen, all strobes 0, halt=1. Only rst_n clears it.
//  - Reset mid-instruction: abandon it; the next cycle after release is T0.
// CONFIGURATION
//  SEQ_EARLY_END_EN defined:
//  - t_state returns to 0 the cycle after an instruction's last non-empty step.
//  - Resulting cycle counts: NOP/JMP/JC/JZ/LDI/OUT = 3, LDA/STA = 4, ADD/SUB = 5.
//  - A not-taken JC/JZ also ends after T2.
//  SEQ_EARLY_END_EN undefined: every instruction takes exactly MAX_STEPS cycles.
// STRUCTURE
//  - Package asap_ctrl_pkg:
//    - opcode localparams (OP_NOP..OP_HLT);
//    - control-word bit index constants;
//    - CTRL_W width constant.
//  - Sub-module microcode_rom:
//    - combinational (opcode, t_state, zf_q, cf_q) -> control word, plus a last_step flag used by early end.
//  - control_sequencer keeps the step counter, halted, and the flags register.
// TESTING
//  - Reset: hold rst_n=0 for 2 clk -> t_state=0, halt=0, all strobes 0; first cycle after release shows pc_oe=mar_ld=1.
//  - ADD (0010) after LDA with A=0xF0, B=0x20:
//    - T4 asserts alu_oe, a_ld, flags_ld.
//    - cf_q=1, zf_q=0 afterward.
//    - no cycle has two *_oe high.
//  - SUB (0011) with A=B=0x05:
//    - alu_sub=1 in T3 and T4;
//    - zf_q=1 after T4;
//    - a following JZ asserts pc_ld in T2.
//  - JC with cf_q=0 -> no pc_ld.
//    - early-end build: t_state sequence 0,1,2,0.
//    - default build: 0,1,2,3,4,0.
//  - HLT (1111):
//    - halt=1 from the cycle after T2;
//    - t_state frozen and all strobes 0 for 20 cycles;
//    - rst_n pulse restores T0.
//  - Reset asserted in T3 of STA -> ram_we never asserted; the next cycle after release is T0.

Source files
------------

// File: rtl/asap_ctrl_pkg.sv
// asap_ctrl_pkg: opcodes, control-word bit positions and width for the ASAP-1 sequencer.
package asap_ctrl_pkg;
    localparam int CTRL_W = 15;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int C_PC_OE    = 0;
    localparam int C_PC_INC   = 1;
    localparam int C_PC_LD    = 2;
    localparam int C_MAR_LD   = 3;
    localparam int C_RAM_OE   = 4;
    localparam int C_RAM_WE   = 5;
    localparam int C_IR_LD    = 6;
    localparam int C_IR_OE    = 7;
    localparam int C_A_LD     = 8;
    localparam int C_A_OE     = 9;
    localparam int C_B_LD     = 10;
    localparam int C_ALU_OE   = 11;
    localparam int C_ALU_SUB  = 12;
    localparam int C_OUT_LD   = 13;
    localparam int C_FLAGS_LD = 14;

    function automatic logic [CTRL_W-1:0] cb(input int i);
        return CTRL_W'(1) << i;
    endfunction
endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: combinational (opcode, T-state, registered flags) -> control word,
// plus last_o marking an instruction's last non-empty step.
module microcode_rom
    import asap_ctrl_pkg::*;
(
    input  logic [3:0]        opcode_i,
    input  logic [2:0]        t_i,
    input  logic              zf_i,
    input  logic              cf_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              last_o
);
    localparam logic [CTRL_W-1:0] IR_TO_MAR = cb(C_IR_OE) | cb(C_MAR_LD);
    localparam logic [CTRL_W-1:0] IR_TO_PC  = cb(C_IR_OE) | cb(C_PC_LD);

    logic t2, t3, t4, sub, long_op, mem_op;

    always_comb begin
        t2 = t_i == 3'd2;
        t3 = t_i == 3'd3;
        t4 = t_i == 3'd4;
        sub = opcode_i == OP_SUB;
        long_op = opcode_i == OP_ADD || sub;
        mem_op = opcode_i == OP_LDA || opcode_i == OP_STA;
        ctrl_o = '0;
        if (t_i == 3'd0)
            ctrl_o = cb(C_PC_OE) | cb(C_MAR_LD);
        else if (t_i == 3'd1)
            ctrl_o = cb(C_RAM_OE) | cb(C_IR_LD) | cb(C_PC_INC);
        else
            case (opcode_i)
                OP_LDA: ctrl_o = t2 ? IR_TO_MAR : t3 ? cb(C_RAM_OE) | cb(C_A_LD) : '0;
                OP_ADD,
                OP_SUB: ctrl_o = t2 ? IR_TO_MAR
                               : t3 ? cb(C_RAM_OE) | cb(C_B_LD) | (sub ? cb(C_ALU_SUB) : '0)
                               : t4 ? cb(C_ALU_OE) | cb(C_A_LD) | cb(C_FLAGS_LD) | (sub ? cb(C_ALU_SUB) : '0)
                               : '0;
                OP_STA: ctrl_o = t2 ? IR_TO_MAR : t3 ? cb(C_A_OE) | cb(C_RAM_WE) : '0;
                OP_LDI: ctrl_o = t2 ? cb(C_IR_OE) | cb(C_A_LD) : '0;
                OP_JMP: ctrl_o = t2 ? IR_TO_PC : '0;
                OP_JC:  ctrl_o = t2 && cf_i ? IR_TO_PC : '0;
                OP_JZ:  ctrl_o = t2 && zf_i ? IR_TO_PC : '0;
                OP_OUT: ctrl_o = t2 ? cb(C_A_OE) | cb(C_OUT_LD) : '0;
                default: ctrl_o = '0;
            endcase
        // Empty execute steps still end at T2, so short instructions take 3 cycles.
        last_o = t_i == (long_op ? 3'd4 : mem_op ? 3'd3 : 3'd2);
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: ASAP-1 T-state sequencer with flags register and HLT.
// Define SEQ_EARLY_END_EN to end each instruction right after its last non-empty step.
module control_sequencer
    import asap_ctrl_pkg::*;
#(
    parameter int MAX_STEPS = 5,
    parameter int OPCODE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zf,
    input  logic                cf,
    output logic [2:0]          t_state,
    output logic                pc_oe,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                mar_ld,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_ld,
    output logic                ir_oe,
    output logic                a_ld,
    output logic                a_oe,
    output logic                b_ld,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                out_ld,
    output logic                flags_ld,
    output logic                halt
);
`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY_END = 1'b1;
`else
    localparam bit EARLY_END = 1'b0;
`endif

    logic [2:0]        t_q, t_d;
    logic              halted_q, halted_d, zf_q, zf_d, cf_q, cf_d;
    logic [CTRL_W-1:0] rom_ctrl, ctrl;
    logic              last_step, step_end, halting;

    microcode_rom u_rom (
        .opcode_i(opcode),
        .t_i     (t_q),
        .zf_i    (zf_q),
        .cf_i    (cf_q),
        .ctrl_o  (rom_ctrl),
        .last_o  (last_step)
    );

    always_comb begin
        ctrl = (rst_n && !halted_q) ? rom_ctrl : '0;
        step_end = (EARLY_END && last_step) || t_q == 3'(MAX_STEPS - 1);
        halting = !halted_q && opcode == OP_HLT && t_q == 3'd2;
        // Halting freezes the counter on the T2 that executed HLT.
        t_d = (halted_q || halting) ? t_q : step_end ? 3'd0 : t_q + 3'd1;
        halted_d = halted_q || halting;
        zf_d = ctrl[C_FLAGS_LD] ? zf : zf_q;
        cf_d = ctrl[C_FLAGS_LD] ? cf : cf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q <= '0;
            halted_q <= 1'b0;
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else begin
            t_q <= t_d;
            halted_q <= halted_d;
            zf_q <= zf_d;
            cf_q <= cf_d;
        end
    end

    assign t_state  = t_q;
    assign halt     = halted_q;
    assign pc_oe    = ctrl[C_PC_OE];
    assign pc_inc   = ctrl[C_PC_INC];
    assign pc_ld    = ctrl[C_PC_LD];
    assign mar_ld   = ctrl[C_MAR_LD];
    assign ram_oe   = ctrl[C_RAM_OE];
    assign ram_we   = ctrl[C_RAM_WE];
    assign ir_ld    = ctrl[C_IR_LD];
    assign ir_oe    = ctrl[C_IR_OE];
    assign a_ld     = ctrl[C_A_LD];
    assign a_oe     = ctrl[C_A_OE];
    assign b_ld     = ctrl[C_B_LD];
    assign alu_oe   = ctrl[C_ALU_OE];
    assign alu_sub  = ctrl[C_ALU_SUB];
    assign out_ld   = ctrl[C_OUT_LD];
    assign flags_ld = ctrl[C_FLAGS_LD];
endmodule
